// File: rtl/gate_chain_pipe.sv
// gate_chain_pipe: two-stage valid/ready pipeline reducing N_IN operands through cascaded selectable gates
//   clk, rst_n           clock, synchronous active-low reset
//   in_data/op_a/op_b    operands (i at [i*WIDTH +: WIDTH]) and per-transaction gate ops
//   in_valid/in_ready    input handshake
//   out_data/out_valid/out_ready  result handshake
//   cnt_clr/hit_cnt      saturating count of transferred nonzero results
module gate_chain_pipe #(
  parameter int WIDTH = 1,
  parameter int N_IN  = 3,
  parameter int SPLIT = 2,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  input  logic [1:0]              op_a,
  input  logic [1:0]              op_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        hit_cnt
);
  if (N_IN < 2 || SPLIT < 1 || SPLIT > N_IN - 1) begin : g_bad_params
    $error("gate_chain_pipe: illegal N_IN/SPLIT");
  end

  // NAND shares AND as its base op; inversion is applied once at the end of each gate
  function automatic logic [WIDTH-1:0] base_op(input logic [1:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (op == 2'b01) ? (x | y) : (op == 2'b10) ? (x ^ y) : (x & y);
  endfunction

  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d, out_data_q, out_data_d, ga, gb, res;
  logic [1:0]       op_b_q, op_b_d;
  logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic             s2_load, s1_load, accept, hit;

  always_comb begin
    s2_load = !out_valid_q || out_ready;
    s1_load = !s1_valid_q || s2_load;
    in_ready = rst_n && s1_load;
    accept = in_valid && in_ready;
    ga = in_data[0 +: WIDTH];
    for (int i = 1; i < SPLIT; i++) ga = base_op(op_a, ga, in_data[i*WIDTH +: WIDTH]);
    gb = in_data[SPLIT*WIDTH +: WIDTH];
    for (int i = SPLIT + 1; i < N_IN; i++) gb = base_op(op_b, gb, in_data[i*WIDTH +: WIDTH]);
    a1_d = accept ? ((op_a == 2'b11) ? ~ga : ga) : a1_q;
    // b1 holds only the base reduction so gate B's NAND inverts across all its operands together
    b1_d = accept ? gb : b1_q;
    op_b_d = accept ? op_b : op_b_q;
    s1_valid_d = accept || (s1_valid_q && !s2_load);
    res = base_op(op_b_q, a1_q, b1_q);
    out_valid_d = s2_load ? s1_valid_q : out_valid_q;
    out_data_d = (s2_load && s1_valid_q) ? ((op_b_q == 2'b11) ? ~res : res) : out_data_q;
    hit = out_valid_q && out_ready && (|out_data_q);
    hit_cnt_d = cnt_clr ? '0 : (hit && !(&hit_cnt_q)) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a1_q <= '0;
      b1_q <= '0;
      op_b_q <= '0;
      s1_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      a1_q <= a1_d;
      b1_q <= b1_d;
      op_b_q <= op_b_d;
      s1_valid_q <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign hit_cnt = hit_cnt_q;
endmodule

// File: tb/tb_gate_chain_pipe.sv
// tb_gate_chain_pipe: randomized and directed checks of gate_chain_pipe in two parameterisations
module tb_gate_chain_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, out_ready, cnt_clr;
  logic [1:0] op_a, op_b;
  logic [2:0] d0;
  logic [15:0] d1;
  logic rdy0, ov0, od0, rdy1, ov1;
  logic [3:0] od1;
  logic [7:0] hc0;
  logic [1:0] hc1;

  gate_chain_pipe u0 (
    .clk(clk), .rst_n(rst_n), .in_data(d0), .op_a(op_a), .op_b(op_b),
    .in_valid(in_valid), .in_ready(rdy0), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .hit_cnt(hc0)
  );

  gate_chain_pipe #(.WIDTH(4), .N_IN(4), .SPLIT(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1), .op_a(op_a), .op_b(op_b),
    .in_valid(in_valid), .in_ready(rdy1), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .cnt_clr(cnt_clr), .hit_cnt(hc1)
  );

  int total = 0;
  int bad = 0;
  bit armed = 0;
  logic [3:0] q0[$], q1[$];
  logic [7:0] cnt0_m = '0;
  logic [1:0] cnt1_m = '0;
  bit hit0, hit1;

  // one N-ary gate over the first n operands, straight from the gate definitions
  function automatic logic [3:0] nary(input logic [1:0] op, input logic [3:0] v [4], input int n);
    logic [3:0] r;
    r = (op == 2'b01 || op == 2'b10) ? 4'h0 : 4'hF;
    for (int i = 0; i < n; i++) r = (op == 2'b01) ? (r | v[i]) : (op == 2'b10) ? (r ^ v[i]) : (r & v[i]);
    return (op == 2'b11) ? ~r : r;
  endfunction

  function automatic logic [3:0] ref0(input logic [2:0] d, input logic [1:0] oa, input logic [1:0] ob);
    logic [3:0] v [4];
    logic [3:0] v2 [4];
    logic [3:0] a, r;
    v = '{{4{d[0]}}, {4{d[1]}}, {4{d[2]}}, 4'h0};
    a = nary(oa, v, 2);
    v2 = '{a, {4{d[2]}}, 4'h0, 4'h0};
    r = nary(ob, v2, 2);
    return {3'b000, r[0]};
  endfunction

  function automatic logic [3:0] ref1(input logic [15:0] d, input logic [1:0] oa, input logic [1:0] ob);
    logic [3:0] v [4];
    logic [3:0] v2 [4];
    logic [3:0] a;
    v = '{d[3:0], d[7:4], d[11:8], d[15:12]};
    a = nary(oa, v, 1);
    v2 = '{a, v[1], v[2], v[3]};
    return nary(ob, v2, 4);
  endfunction

  // scoreboard: results must leave in acceptance order; hit_cnt tracked against a model
  always @(negedge clk) begin
    if (armed) begin
      total += 2;
      if (hc0 !== cnt0_m) begin bad++; $display("FAIL hit_cnt0 got=%0d want=%0d", hc0, cnt0_m); end
      if (hc1 !== cnt1_m) begin bad++; $display("FAIL hit_cnt1 got=%0d want=%0d", hc1, cnt1_m); end
      if (!rst_n) begin
        q0.delete();
        q1.delete();
        cnt0_m = '0;
        cnt1_m = '0;
      end else begin
        hit0 = 0;
        hit1 = 0;
        if (ov0 && out_ready) begin
          total++;
          if (q0.size() == 0) begin bad++; $display("FAIL stale0 got=%b want=no_result", od0); end
          else begin
            if (od0 !== q0[0][0]) begin bad++; $display("FAIL out0 got=%b want=%b", od0, q0[0][0]); end
            hit0 = q0[0] != 0;
            void'(q0.pop_front());
          end
        end
        if (ov1 && out_ready) begin
          total++;
          if (q1.size() == 0) begin bad++; $display("FAIL stale1 got=%h want=no_result", od1); end
          else begin
            if (od1 !== q1[0]) begin bad++; $display("FAIL out1 got=%h want=%h", od1, q1[0]); end
            hit1 = q1[0] != 0;
            void'(q1.pop_front());
          end
        end
        cnt0_m = cnt_clr ? 8'd0 : (hit0 && cnt0_m != 8'hFF) ? cnt0_m + 8'd1 : cnt0_m;
        cnt1_m = cnt_clr ? 2'd0 : (hit1 && cnt1_m != 2'd3) ? cnt1_m + 2'd1 : cnt1_m;
        if (in_valid && rdy0) begin
          q0.push_back(ref0(d0, op_a, op_b));
          q1.push_back(ref1(d1, op_a, op_b));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 0; cnt_clr = 0; op_a = 0; op_b = 0; d0 = 0; d1 = 0;
    cyc(); cyc();
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", rdy0); end
    total++; if (ov0 !== 1'b0 || ov1 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b%b want=00", ov0, ov1); end
    total++; if (od0 !== 1'b0 || od1 !== 4'h0) begin bad++; $display("FAIL reset_out_data got=%b/%h want=0/0", od0, od1); end
    total++; if (hc0 !== 8'd0 || hc1 !== 2'd0) begin bad++; $display("FAIL reset_hit_cnt got=%0d/%0d want=0/0", hc0, hc1); end
    armed = 1;
    rst_n = 1;
    #1;
    total++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b%b want=11", rdy0, rdy1); end
  endtask

  task automatic test_basic();
    logic [2:0] s [4];
    logic e [4];
    s = '{3'b000, 3'b110, 3'b001, 3'b111};
    e = '{1'b0, 1'b1, 1'b0, 1'b1};
    op_a = 2'b00; op_b = 2'b01; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      if (i < 4) d0 = s[i];
      d1 = 16'($urandom);
      cyc();
      total++;
      if (i >= 1 && i <= 4) begin
        if (ov0 !== 1'b1 || od0 !== e[i-1]) begin bad++; $display("FAIL basic_%0d got=%b/%b want=1/%b", i, ov0, od0, e[i-1]); end
      end else if (ov0 !== 1'b0) begin bad++; $display("FAIL basic_latency_%0d got=%b want=0", i, ov0); end
    end
    total++; if (hc0 !== 8'd2) begin bad++; $display("FAIL basic_hit_cnt got=%0d want=2", hc0); end
  endtask

  task automatic test_wide();
    op_a = 2'b11; op_b = 2'b10; out_ready = 1;
    in_valid = 1; d1 = 16'h053F; d0 = 3'($urandom);
    cyc();
    in_valid = 0;
    cyc();
    total++; if (ov1 !== 1'b1 || od1 !== 4'h6) begin bad++; $display("FAIL wide got=%b/%h want=1/6", ov1, od1); end
    cyc(); cyc();
  endtask

  task automatic test_backpressure();
    logic h0;
    logic [3:0] h1;
    int n;
    out_ready = 0; op_a = 2'($urandom); op_b = 2'($urandom);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; d0 = 3'($urandom); d1 = 16'($urandom);
      #1;
      total++; if (rdy0 !== (i < 2)) begin bad++; $display("FAIL bp_ready_%0d got=%b want=%b", i, rdy0, i < 2); end
      if (i < 2) cyc();
    end
    h0 = od0; h1 = od1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (ov1 !== 1'b1 || od1 !== h1 || od0 !== h0 || rdy0 !== 1'b0)
        begin bad++; $display("FAIL bp_hold_%0d got=%b/%h/%b/rdy%b want=1/%h/%b/rdy0", k, ov1, od1, od0, rdy0, h1, h0); end
    end
    out_ready = 1;
    #1;
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL bp_full_advance got=%b want=1", rdy0); end
    cyc();
    in_valid = 0;
    n = 0;
    while (q0.size() != 0 && n < 10) begin cyc(); n++; end
    total++; if (q0.size() != 0 || ov0 !== 1'b0) begin bad++; $display("FAIL bp_drain got=left%0d/ov%b want=left0/ov0", q0.size(), ov0); end
  endtask

  task automatic test_op_change();
    op_a = 2'b00; out_ready = 1;
    in_valid = 1; d0 = 3'b111; op_b = 2'b01; d1 = 16'($urandom);
    cyc();
    d0 = 3'b000; op_b = 2'b11; d1 = 16'($urandom);
    cyc();
    in_valid = 0; op_b = 2'b00; op_a = 2'b10;
    total++; if (ov0 !== 1'b1 || od0 !== 1'b1) begin bad++; $display("FAIL opchg_first got=%b/%b want=1/1", ov0, od0); end
    cyc();
    total++; if (ov0 !== 1'b1 || od0 !== 1'b1) begin bad++; $display("FAIL opchg_second got=%b/%b want=1/1", ov0, od0); end
    cyc(); cyc();
  endtask

  task automatic test_sat();
    op_a = 2'b01; op_b = 2'b01; out_ready = 1; in_valid = 0;
    cnt_clr = 1;
    cyc();
    cnt_clr = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; d1 = 16'($urandom) | 16'h0001; d0 = 3'($urandom);
      cyc();
    end
    in_valid = 0;
    cyc(); cyc(); cyc();
    total++; if (hc1 !== 2'd3) begin bad++; $display("FAIL sat got=%0d want=3", hc1); end
    in_valid = 1; d1 = 16'h0001; d0 = 3'b001;
    cyc();
    in_valid = 0;
    cyc();
    total++; if (ov1 !== 1'b1 || od1 === 4'h0) begin bad++; $display("FAIL clr_setup got=%b/%h want=1/nonzero", ov1, od1); end
    cnt_clr = 1;
    cyc();
    cnt_clr = 0;
    total++; if (hc1 !== 2'd0 || hc0 !== 8'd0) begin bad++; $display("FAIL clr_wins got=%0d/%0d want=0/0", hc1, hc0); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0; op_a = 2'($urandom); op_b = 2'($urandom);
    in_valid = 1; d0 = 3'b111; d1 = 16'hFFFF;
    cyc();
    d0 = 3'($urandom); d1 = 16'($urandom);
    cyc();
    in_valid = 0; rst_n = 0;
    cyc();
    total++; if (ov0 !== 1'b0 || ov1 !== 1'b0 || od0 !== 1'b0 || od1 !== 4'h0)
      begin bad++; $display("FAIL midrst_out got=%b%b/%b/%h want=00/0/0", ov0, ov1, od0, od1); end
    total++; if (hc0 !== 8'd0 || hc1 !== 2'd0) begin bad++; $display("FAIL midrst_cnt got=%0d/%0d want=0/0", hc0, hc1); end
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL midrst_ready_low got=%b want=0", rdy0); end
    rst_n = 1; out_ready = 1;
    #1;
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL midrst_ready_high got=%b want=1", rdy0); end
    cyc(); cyc(); cyc();
    total++; if (ov0 !== 1'b0 || ov1 !== 1'b0) begin bad++; $display("FAIL midrst_no_stale got=%b%b want=00", ov0, ov1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom); out_ready = ($urandom % 4) != 0;
      op_a = 2'($urandom); op_b = 2'($urandom);
      d0 = 3'($urandom); d1 = 16'($urandom);
      cnt_clr = ($urandom % 16) == 0;
      cyc();
    end
    in_valid = 0; out_ready = 1; cnt_clr = 0;
    repeat (4) cyc();
    total++; if (q0.size() != 0 || q1.size() != 0 || ov0 !== 1'b0)
      begin bad++; $display("FAIL rand_drain got=left%0d/%0d ov%b want=left0/0 ov0", q0.size(), q1.size(), ov0); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_backpressure();
    test_op_change();
    test_sat();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
